// File: rtl/boot_loader.sv
// Streams boot words into IM then DM through their SRAM write ports while holding the CPU in reset.
// Optional trailer checksum: define BOOT_CHECKSUM_EN.
module boot_loader #(
    parameter int IM_WORDS = 16384,
    parameter int DM_WORDS = 16384,
    parameter int AW       = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    output logic          im_cs,
    output logic          im_oe,
    output logic [3:0]    im_web,
    output logic [AW-1:0] im_a,
    output logic [31:0]   im_di,
    output logic          dm_cs,
    output logic          dm_oe,
    output logic [3:0]    dm_web,
    output logic [AW-1:0] dm_a,
    output logic [31:0]   dm_di,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IM,
        LOAD_DM,
`ifdef BOOT_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    localparam logic [AW:0] IM_LAST = (AW+1)'(IM_WORDS - 1);
    localparam logic [AW:0] DM_LAST = (AW+1)'(DM_WORDS - 1);

    state_t      state;
    state_t      nxt;
    logic [AW:0] cnt;
    logic        hs;
    logic        restart;
    logic        in_im;
    logic        in_dm;
    logic        err_q;

    assign hs      = s_valid & s_ready;
    assign in_im   = (state == LOAD_IM);
    assign in_dm   = (state == LOAD_DM);
    assign restart = start & ((state == IDLE) | (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt     = state;
        s_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) nxt = LOAD_IM;
            end
            LOAD_IM: begin
                s_ready = 1'b1;
                if (s_valid && cnt == IM_LAST) nxt = LOAD_DM;
            end
            LOAD_DM: begin
                s_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                if (s_valid && cnt == DM_LAST) nxt = CHECK;
`else
                if (s_valid && cnt == DM_LAST) nxt = DONE;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                s_ready = 1'b1;
                if (s_valid) nxt = DONE;
            end
`endif
            DONE: begin
                if (start) nxt = LOAD_IM;
            end
            default: nxt = IDLE;
        endcase
    end

    // Writes are registered: the SRAM sees each word one cycle after its handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            im_cs   <= 1'b0;
            dm_cs   <= 1'b0;
            im_a    <= '0;
            dm_a    <= '0;
            im_di   <= '0;
            dm_di   <= '0;
            cpu_rst <= 1'b1;
        end else begin
            im_cs   <= hs & in_im;
            dm_cs   <= hs & in_dm;
            cpu_rst <= !((state == DONE) && !start && !err_q);
            if (hs && in_im) begin
                im_a  <= cnt[AW-1:0];
                im_di <= s_data;
            end
            if (hs && in_dm) begin
                dm_a  <= cnt[AW-1:0];
                dm_di <= s_data;
            end
            if (restart)
                cnt <= '0;
            else if (hs && in_im && cnt == IM_LAST)
                cnt <= '0;
            else if (hs && (in_im || in_dm))
                cnt <= cnt + 1'b1;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (restart) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (hs && (in_im || in_dm)) begin
            sum <= sum + s_data;
        end else if (hs && state == CHECK) begin
            err_q <= (s_data != sum);
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign im_oe  = 1'b0;
    assign dm_oe  = 1'b0;
    assign im_web = {4{~im_cs}};
    assign dm_web = {4{~dm_cs}};
    assign done   = (state == DONE);
    assign err    = err_q;

endmodule

// File: doc/boot_loader.md
# boot_loader

Hardware counterpart to the bench's backdoor program load. It accepts a stream of 32-bit words from an external boot source and writes them into the instruction SRAM (IM) and data SRAM (DM) through their normal SRAM ports, while holding the CPU in reset. It sits in `top` between the boot source and the IM/DM SRAM wrappers and releases the CPU once both memories are filled. The data layout matches the bench: word i of the stream goes to IM[i] for i < IM_WORDS, and to DM[i − IM_WORDS] otherwise.

## Interface
Parameters:
- IM_WORDS, 16384, number of words loaded into IM.
- DM_WORDS, 16384, number of words loaded into DM.
- AW, 14, SRAM word-address width; must satisfy 2^AW ≥ max(IM_WORDS, DM_WORDS).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Ignored unless the block is in IDLE or DONE.
- s_valid  in  1  source word valid.
- s_data  in  32  source word.
- s_ready  out  1  block accepts the word this cycle.
- im_cs / dm_cs  out  1  SRAM chip select.
- im_oe / dm_oe  out  1  SRAM output enable; held at 0.
- im_web / dm_web  out  4  per-byte write enable, active low.
- im_a / dm_a  out  AW  SRAM word address.
- im_di / dm_di  out  32  SRAM write data.
- cpu_rst  out  1  reset to the CPU; high until the load completes.
- done  out  1  load complete; level signal.
- err  out  1  checksum mismatch; only present with BOOT_CHECKSUM_EN, otherwise tied to 0.

## Operation
- States: IDLE, LOAD_IM, LOAD_DM, CHECK (only with the macro), DONE.
- IDLE
  - s_ready = 0; cpu_rst = 1.
  - start moves to LOAD_IM and clears the word counter cnt.
- LOAD_IM
  - s_ready = 1.
  - Each handshake (s_valid & s_ready) registers the word and writes it to IM at address cnt, then increments cnt.
  - On the handshake where cnt == IM_WORDS−1: clear cnt and go to LOAD_DM.
- LOAD_DM
  - Same as LOAD_IM, targeting DM.
  - On the handshake where cnt == DM_WORDS−1: go to DONE (or CHECK with the macro).
- DONE
  - s_ready = 0; done = 1.
  - cpu_rst drops to 0 one cycle after DONE is entered.
  - start restarts the load from LOAD_IM: done clears and cpu_rst rises in the same cycle.
- Write port behaviour
  - cs = 1 and web = 4'b0000 only in the cycle after a handshake.
  - Otherwise cs = 0, web = 4'b1111, and a/di hold their last values.
  - The IM port and the DM port are never active in the same cycle.
- Source stall: s_valid low inserts an idle cycle with no write. The counter and state hold.
- Extra words are never accepted: s_ready is 0 outside the LOAD states.
- Counter width: AW+1 bits; no wrap within a load.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, s_ready = 0.
  - im_cs = dm_cs = 0, im_oe = dm_oe = 0.
  - im_web = dm_web = 4'b1111, im_a = dm_a = 0, im_di = dm_di = 0.
  - cpu_rst = 1, done = 0, err = 0.
- Write latency: the SRAM write is presented exactly 1 cycle after its handshake.
- Back-to-back handshakes produce back-to-back writes, one word per cycle.
- IM→DM boundary: the last IM write and the first DM write may occur in consecutive cycles with no bubble.
- DONE is entered in the same cycle the last DM write is presented.
- rst mid-load:
  - All outputs return to their reset values on the next edge.
  - The partially written SRAM contents are left as they are.
  - A new start is required.
- start during LOAD_IM, LOAD_DM or CHECK is ignored.

## Configuration
- Macro BOOT_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum, modulo 2^32, is kept over every written word.
  - After the last DM word the block enters CHECK, with s_ready = 1, and accepts exactly one trailer word without writing it.
  - Trailer equal to the sum: go to DONE.
  - Trailer different: go to DONE, set err = 1, and hold cpu_rst = 1.
  - err clears on start or rst.
- Undefined:
  - No CHECK state, no trailer.
  - err is constant 0.

## Test plan
All scenarios use IM_WORDS = 4, DM_WORDS = 4.
- Reset, then start, then stream 0x11..0x18 with s_valid held high:
  - IM[0..3] = 0x11..0x14 and DM[0..3] = 0x15..0x18.
  - 8 consecutive write cycles.
  - done rises; cpu_rst falls one cycle later.
- Same stream with s_valid low every other cycle:
  - Identical memory contents.
  - No write in the stall cycles; writes occur exactly 1 cycle after each handshake.
- rst asserted after 3 words have been accepted:
  - All outputs return to reset values on the next edge.
  - A following start plus 8 words loads correctly from IM[0].
- start pulsed mid-load and s_valid high while in IDLE:
  - No state change.
  - s_ready stays 0 in IDLE, and no write occurs.
- BOOT_CHECKSUM_EN:
  - Stream 1..8 with trailer 0x24: done = 1, err = 0, cpu_rst = 0.
  - Same stream with trailer 0x25: done = 1, err = 1, cpu_rst stays 1.
- From DONE, start again with a new stream: done clears immediately, and the memories are overwritten.
